// File: rtl/demux_ctrl_pkg.sv
// Shared types and constants for the demux dispatch controller.
package demux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_e;

  localparam logic [1:0] MODE_FIXA = 2'b00;
  localparam logic [1:0] MODE_FIXB = 2'b01;
  localparam logic [1:0] MODE_ALT  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/demux_dispatch_ctrl_credit_counter.sv
// Outstanding-beat counter for one consumer: +1 per delivered beat, -1 per done pulse,
// saturating at 0 and MAX_OUT; simultaneous inc and dec cancel.
module credit_counter #(
  parameter int MAX_OUT = 4,
  localparam int CW = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          has_credit
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q < CW'(MAX_OUT)) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count      = count_q;
  assign has_credit = (count_q < CW'(MAX_OUT));

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Single-input, dual-output beat dispatcher with selectable routing policy and
// per-output credit limits. One beat in flight at a time.
module demux_dispatch_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             a_valid,
  output logic             b_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             a_done,
  input  logic             b_done,
  output logic             sel,
  output logic             busy
);

  localparam int CW = $clog2(MAX_OUT + 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             a_valid_q, b_valid_q, sel_q, busy_q, ptr_q;
  logic [CW-1:0]    cnt_a, cnt_b;
  logic             has_a, has_b;
  logic             tgt_ok, tgt_b, accept, hs_a, hs_b;

  always_comb begin
    tgt_ok = 1'b0;
    tgt_b  = 1'b0;
    case (mode)
      MODE_FIXA: begin
        tgt_ok = has_a;
        tgt_b  = 1'b0;
      end
      MODE_FIXB: begin
        tgt_ok = has_b;
        tgt_b  = 1'b1;
      end
      MODE_ALT: begin
        // The pointer target stalls when full; it never falls over to the other side.
        tgt_b  = ptr_q;
        tgt_ok = ptr_q ? has_b : has_a;
      end
      default: begin
        if (has_a && has_b) begin
          tgt_ok = 1'b1;
          tgt_b  = (cnt_a == cnt_b) ? !sel_q : (cnt_b < cnt_a);
        end else begin
          tgt_ok = has_a || has_b;
          tgt_b  = !has_a;
        end
      end
    endcase
  end

  assign in_ready = !rst && (state_q == IDLE) && tgt_ok;
  assign accept   = in_valid && in_ready;
  assign hs_a     = (state_q == SEND_A) && a_ready;
  assign hs_b     = (state_q == SEND_B) && b_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sel_q  <= tgt_b;
            busy_q <= 1'b1;
            if (mode == MODE_ALT) ptr_q <= ~ptr_q;
            if (tgt_b) begin
              b_q       <= in;
              b_valid_q <= 1'b1;
              state_q   <= SEND_B;
            end else begin
              a_q       <= in;
              a_valid_q <= 1'b1;
              state_q   <= SEND_A;
            end
          end
        end
        SEND_A: begin
          if (a_ready) begin
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        SEND_B: begin
          if (b_ready) begin
            b_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  credit_counter #(.MAX_OUT(MAX_OUT)) u_cnt_a (
    .clk(clk), .rst(rst), .inc(hs_a), .dec(a_done), .count(cnt_a), .has_credit(has_a)
  );

  credit_counter #(.MAX_OUT(MAX_OUT)) u_cnt_b (
    .clk(clk), .rst(rst), .inc(hs_b), .dec(b_done), .count(cnt_b), .has_credit(has_b)
  );

  assign a       = a_q;
  assign b       = b_q;
  assign a_valid = a_valid_q;
  assign b_valid = b_valid_q;
  assign sel     = sel_q;
  assign busy    = busy_q;

endmodule
